// File: rtl/grid_write_arbiter_if.sv
// Write-side bundle of grid_write_arbiter: two req/ack write ports, the clear
// control and the grid contents seen by the video scan-out.
interface grid_write_arbiter_if #(
    parameter int RAM_LENGTH = 1200
);
    logic                  req0;
    logic [4:0]            row0;
    logic [5:0]            col0;
    logic                  val0;
    logic                  ack0;
    logic                  req1;
    logic [4:0]            row1;
    logic [5:0]            col1;
    logic                  val1;
    logic                  ack1;
    logic                  clear_start;
    logic                  clear_busy;
    logic                  err_oob;
    logic [RAM_LENGTH-1:0] grid_ram;

    modport master (
        output req0, row0, col0, val0,
        output req1, row1, col1, val1,
        output clear_start,
        input  ack0, ack1, clear_busy, err_oob, grid_ram
    );

    modport slave (
        input  req0, row0, col0, val0,
        input  req1, row1, col1, val1,
        input  clear_start,
        output ack0, ack1, clear_busy, err_oob, grid_ram
    );
endinterface

// File: rtl/grid_write_arbiter.sv
// Round-robin arbiter for two writers into the one-bit-per-cell display grid.
// Define GRID_ARB_CLEAR_EN to build in the row-per-cycle clear sequencer.
module grid_write_arbiter #(
    parameter int GRID_ROWS  = 30,
    parameter int GRID_COLS  = 40,
    parameter int RAM_LENGTH = 1200
) (
    input  logic                 clk,
    input  logic                 reset,
    grid_write_arbiter_if.slave  bus
);

    logic [RAM_LENGTH-1:0] grid_q, grid_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic                  err_q, err_d;
    logic                  last_q, last_d;

    logic                  elig0, elig1;
    logic                  grant0, grant1, any_grant;
    logic                  stall;
    logic [4:0]            sel_row;
    logic [5:0]            sel_col;
    logic                  sel_val;
    logic                  in_range;
    logic [10:0]           wr_idx;

`ifdef GRID_ARB_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state_q, state_d;
    logic [4:0]  clear_row_q, clear_row_d;
    logic [10:0] clear_base;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        clear_row_d = clear_row_q;
        case (state_q)
            IDLE: begin
                if (bus.clear_start) begin
                    state_d     = CLEAR;
                    clear_row_d = 5'd0;
                end
            end
            CLEAR: begin
                clear_row_d = clear_row_q + 5'd1;
                if (clear_row_q == 5'(GRID_ROWS - 1)) begin
                    state_d     = IDLE;
                    clear_row_d = 5'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            clear_row_q <= 5'd0;
        end else begin
            state_q     <= state_d;
            clear_row_q <= clear_row_d;
        end
    end

    assign clear_base     = 11'(clear_row_q) * 11'(GRID_COLS);
    // A start sampled in IDLE already blocks grants, so the clear never meets a write.
    assign stall          = (state_q == CLEAR) || bus.clear_start;
    assign bus.clear_busy = (state_q == CLEAR);
`else
    logic unused_clear_start;
    assign unused_clear_start = bus.clear_start;
    assign stall              = 1'b0;
    assign bus.clear_busy     = 1'b0;
`endif

    // A requester whose ack is currently high has just been served and sits out a cycle.
    assign elig0 = bus.req0 && !ack0_q;
    assign elig1 = bus.req1 && !ack1_q;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!stall) begin
            if (elig0 && elig1) begin
                grant0 = last_q;
                grant1 = !last_q;
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    assign any_grant = grant0 || grant1;
    assign sel_row   = grant1 ? bus.row1 : bus.row0;
    assign sel_col   = grant1 ? bus.col1 : bus.col0;
    assign sel_val   = grant1 ? bus.val1 : bus.val0;
    assign in_range  = (sel_row < 5'(GRID_ROWS)) && (sel_col < 6'(GRID_COLS));
    assign wr_idx    = 11'(sel_row) * 11'(GRID_COLS) + 11'(sel_col);

    always_comb begin
        grid_d = grid_q;
        if (any_grant && in_range) begin
            grid_d[wr_idx] = sel_val;
        end
`ifdef GRID_ARB_CLEAR_EN
        if (state_q == CLEAR) begin
            grid_d[clear_base +: GRID_COLS] = '0;
        end
`endif
        ack0_d = grant0;
        ack1_d = grant1;
        err_d  = any_grant && !in_range;
        last_d = last_q;
        if (grant0) begin
            last_d = 1'b0;
        end else if (grant1) begin
            last_d = 1'b1;
        end
    end

    // NOTE: the grid is a flop array the scan-out reads directly, so it is reset like any other state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grid_q <= '0;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err_q  <= 1'b0;
            last_q <= 1'b1;
        end else begin
            grid_q <= grid_d;
            ack0_q <= ack0_d;
            ack1_q <= ack1_d;
            err_q  <= err_d;
            last_q <= last_d;
        end
    end

    assign bus.grid_ram = grid_q;
    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.err_oob  = err_q;

endmodule

// File: tb/tb_grid_write_arbiter.sv
// Directed bench for grid_write_arbiter; clear-sequencer scenarios run only
// when GRID_ARB_CLEAR_EN is defined, the disabled-clear scenarios otherwise.
module tb_grid_write_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    grid_write_arbiter_if #(.RAM_LENGTH(1200)) bus ();

    grid_write_arbiter #(
        .GRID_ROWS  (30),
        .GRID_COLS  (40),
        .RAM_LENGTH (1200)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [1199:0] exp_grid;

    function automatic int first_diff(input logic [1199:0] a, input logic [1199:0] b);
        for (int i = 0; i < 1200; i++) begin
            if (a[i] !== b[i]) return i;
        end
        return -1;
    endfunction

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.row0 = '0; bus.col0 = '0; bus.val0 = 1'b0;
        bus.req1 = 1'b0; bus.row1 = '0; bus.col1 = '0; bus.val1 = 1'b0;
        bus.clear_start = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        exp_grid = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.grid_ram !== exp_grid) begin
            errors++;
            $display("FAIL reset_grid ones=%0d exp_ones=0 first_diff=%0d",
                     $countones(bus.grid_ram), first_diff(bus.grid_ram, exp_grid));
        end
        checks++;
        if ({bus.ack0, bus.ack1, bus.err_oob, bus.clear_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags ack0/ack1/err/busy=%b expected 0000",
                     {bus.ack0, bus.ack1, bus.err_oob, bus.clear_busy});
        end
    endtask

    task automatic test_single_write();
        bus.req0 = 1'b1; bus.row0 = 5'd2; bus.col0 = 6'd5; bus.val0 = 1'b1;
        exp_grid[85] = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.ack0, bus.ack1, bus.err_oob} !== 3'b100) begin
            errors++;
            $display("FAIL single_ack ack0/ack1/err=%b expected 100", {bus.ack0, bus.ack1, bus.err_oob});
        end
        checks++;
        if (bus.grid_ram !== exp_grid) begin
            errors++;
            $display("FAIL single_grid ones=%0d exp_ones=%0d first_diff=%0d",
                     $countones(bus.grid_ram), $countones(exp_grid), first_diff(bus.grid_ram, exp_grid));
        end
        bus.req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ack0 !== 1'b0) begin
            errors++;
            $display("FAIL single_ack_drop ack0=%b expected 0", bus.ack0);
        end
    endtask

    task automatic test_tie_break();
        apply_reset();
        bus.req0 = 1'b1; bus.row0 = 5'd0;  bus.col0 = 6'd0;  bus.val0 = 1'b1;
        bus.req1 = 1'b1; bus.row1 = 5'd29; bus.col1 = 6'd39; bus.val1 = 1'b1;
        exp_grid[0]    = 1'b1;
        exp_grid[1199] = 1'b1;
        // Six granting edges with both held: acks must alternate starting with requester 0.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.ack0, bus.ack1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL tie_alternate step=%0d ack0/ack1=%b expected %b",
                         i, {bus.ack0, bus.ack1}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
        end
        checks++;
        if (bus.grid_ram !== exp_grid) begin
            errors++;
            $display("FAIL tie_grid ones=%0d exp_ones=%0d first_diff=%0d",
                     $countones(bus.grid_ram), $countones(exp_grid), first_diff(bus.grid_ram, exp_grid));
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        for (int k = 0; k < 2; k++) begin
            bus.req1 = 1'b1;
            bus.row1 = (k == 0) ? 5'd30 : 5'd0;
            bus.col1 = (k == 0) ? 6'd0  : 6'd40;
            bus.val1 = 1'b1;
            @(negedge clk);
            checks++;
            if ({bus.ack1, bus.err_oob} !== 2'b11) begin
                errors++;
                $display("FAIL oob_resp case=%0d ack1/err=%b expected 11", k, {bus.ack1, bus.err_oob});
            end
            checks++;
            if (bus.grid_ram !== exp_grid) begin
                errors++;
                $display("FAIL oob_grid case=%0d ones=%0d exp_ones=%0d first_diff=%0d", k,
                         $countones(bus.grid_ram), $countones(exp_grid), first_diff(bus.grid_ram, exp_grid));
            end
            bus.req1 = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.err_oob !== 1'b0) begin
                errors++;
                $display("FAIL oob_pulse case=%0d err=%b expected 0", k, bus.err_oob);
            end
        end
    endtask

    task automatic write0(input logic [4:0] r, input logic [5:0] c, input logic v);
        int waited;
        bus.req0 = 1'b1; bus.row0 = r; bus.col0 = c; bus.val0 = v;
        waited = 0;
        @(negedge clk);
        while (!bus.ack0 && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        checks++;
        if (bus.ack0 !== 1'b1) begin
            errors++;
            $display("FAIL write0_timeout row=%0d col=%0d ack0=%b expected 1", r, c, bus.ack0);
        end
        bus.req0 = 1'b0;
        @(negedge clk);
    endtask

`ifdef GRID_ARB_CLEAR_EN
    task automatic test_clear_pending();
        int busy_cnt;
        logic saw_ack;
        apply_reset();
        write0(5'd0,  6'd0,  1'b1);
        write0(5'd15, 6'd0,  1'b1);
        write0(5'd29, 6'd39, 1'b1);
        exp_grid[0] = 1'b1; exp_grid[600] = 1'b1; exp_grid[1199] = 1'b1;
        checks++;
        if (bus.grid_ram !== exp_grid) begin
            errors++;
            $display("FAIL clear_setup ones=%0d exp_ones=3 first_diff=%0d",
                     $countones(bus.grid_ram), first_diff(bus.grid_ram, exp_grid));
        end
        bus.clear_start = 1'b1;
        bus.req0 = 1'b1; bus.row0 = 5'd0; bus.col0 = 6'd0; bus.val0 = 1'b1;
        @(negedge clk);
        bus.clear_start = 1'b0;
        busy_cnt = 0;
        saw_ack  = 1'b0;
        for (int i = 0; i < 40 && bus.clear_busy; i++) begin
            busy_cnt++;
            if (bus.ack0) saw_ack = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (busy_cnt !== 30) begin
            errors++;
            $display("FAIL clear_busy_len cycles=%0d expected 30", busy_cnt);
        end
        checks++;
        if ({saw_ack, bus.ack0} !== 2'b00) begin
            errors++;
            $display("FAIL clear_stall ack_during/ack_at_fall=%b expected 00", {saw_ack, bus.ack0});
        end
        @(negedge clk);
        exp_grid = '0;
        exp_grid[0] = 1'b1;
        checks++;
        if (bus.ack0 !== 1'b1) begin
            errors++;
            $display("FAIL clear_post_ack ack0=%b expected 1", bus.ack0);
        end
        checks++;
        if (bus.grid_ram !== exp_grid) begin
            errors++;
            $display("FAIL clear_post_grid ones=%0d exp_ones=1 first_diff=%0d",
                     $countones(bus.grid_ram), first_diff(bus.grid_ram, exp_grid));
        end
        bus.req0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        bus.clear_start = 1'b1;
        @(negedge clk);
        bus.clear_start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        exp_grid = '0;
        checks++;
        if ({bus.clear_busy, bus.ack0, bus.grid_ram != '0} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid busy/ack0/grid_nonzero=%b expected 000",
                     {bus.clear_busy, bus.ack0, bus.grid_ram != '0});
        end
        @(negedge clk);
        reset = 1'b0;
        bus.req0 = 1'b1; bus.row0 = 5'd1; bus.col0 = 6'd1; bus.val0 = 1'b1;
        exp_grid[41] = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ack0 !== 1'b1 || bus.grid_ram !== exp_grid) begin
            errors++;
            $display("FAIL reset_mid_serve ack0=%b ones=%0d expected ack0=1 ones=1",
                     bus.ack0, $countones(bus.grid_ram));
        end
        bus.req0 = 1'b0;
        @(negedge clk);
    endtask
`else
    task automatic test_clear_disabled();
        bus.clear_start = 1'b1;
        bus.req0 = 1'b1; bus.row0 = 5'd3; bus.col0 = 6'd3; bus.val0 = 1'b1;
        exp_grid[123] = 1'b1;
        @(negedge clk);
        bus.clear_start = 1'b0;
        checks++;
        if ({bus.clear_busy, bus.ack0} !== 2'b01) begin
            errors++;
            $display("FAIL nclr_no_stall busy/ack0=%b expected 01", {bus.clear_busy, bus.ack0});
        end
        checks++;
        if (bus.grid_ram !== exp_grid) begin
            errors++;
            $display("FAIL nclr_retain ones=%0d exp_ones=%0d first_diff=%0d",
                     $countones(bus.grid_ram), $countones(exp_grid), first_diff(bus.grid_ram, exp_grid));
        end
        // Held request: registered ack gives one grant every other cycle.
        @(negedge clk);
        checks++;
        if ({bus.clear_busy, bus.ack0} !== 2'b00) begin
            errors++;
            $display("FAIL nclr_gap busy/ack0=%b expected 00", {bus.clear_busy, bus.ack0});
        end
        @(negedge clk);
        checks++;
        if ({bus.clear_busy, bus.ack0} !== 2'b01) begin
            errors++;
            $display("FAIL nclr_regrant busy/ack0=%b expected 01", {bus.clear_busy, bus.ack0});
        end
        bus.req0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        bus.req0 = 1'b1; bus.row0 = 5'd4; bus.col0 = 6'd4; bus.val0 = 1'b1;
        reset = 1'b1;
        #1;
        exp_grid = '0;
        checks++;
        if ({bus.ack0, bus.err_oob, bus.grid_ram != '0} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid ack0/err/grid_nonzero=%b expected 000",
                     {bus.ack0, bus.err_oob, bus.grid_ram != '0});
        end
        @(negedge clk);
        reset = 1'b0;
        exp_grid[164] = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ack0 !== 1'b1 || bus.grid_ram !== exp_grid) begin
            errors++;
            $display("FAIL reset_mid_serve ack0=%b ones=%0d expected ack0=1 ones=1",
                     bus.ack0, $countones(bus.grid_ram));
        end
        bus.req0 = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        reset = 1'b1;
        idle_inputs();
        exp_grid = '0;
        test_reset();
        test_single_write();
        test_tie_break();
        test_out_of_range();
`ifdef GRID_ARB_CLEAR_EN
        test_clear_pending();
`else
        test_clear_disabled();
`endif
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/grid_write_arbiter.md
# grid_write_arbiter

Shares write access to the 30x40 one-bit-per-cell display grid between two independent requesters (e.g. cursor logic and a pattern generator), owning the `grid_ram` register the video path reads. It applies round-robin arbitration with a req/ack handshake and bounds-checks coordinates. An optional sequencer clears the grid one row per cycle. It sits between the content-producing logic and the video scan-out, replacing direct writes to `grid_ram`.

## Interface
- `GRID_ROWS`, 30, number of grid rows.
- `GRID_COLS`, 40, number of grid columns.
- `RAM_LENGTH`, 1200, grid bits; must equal `GRID_ROWS*GRID_COLS`.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`  in  1  requester 0 write request.
- `row0`  in  5  requester 0 row.
- `col0`  in  6  requester 0 column.
- `val0`  in  1  requester 0 cell value.
- `ack0`  out  1  requester 0 one-cycle write acknowledge.
- `req1`, `row1`, `col1`, `val1`, `ack1`: same as requester 0, for requester 1.
- `clear_start`  in  1  single-cycle request to clear the whole grid.
- `clear_busy`  out  1  high while the clear sequence runs.
- `err_oob`  out  1  one-cycle pulse when an acked write had out-of-range coordinates.
- `grid_ram`  out  RAM_LENGTH  grid contents; bit index = `row*GRID_COLS+col`.

## Operation
- **Request eligibility:** requester n is eligible when `reqn`=1 and `ackn`=0. `ackn` is registered, so a requester that keeps `req` high is granted at most every other cycle.
- **Grant:** at most one grant per cycle.
  - If only one requester is eligible, it is granted.
  - If both are eligible, grant the one not granted last; the `last_grant` pointer updates on every grant.
- **Write on grant:** on the granting edge:
  - `ackn` is set to 1 for one cycle.
  - If `row<GRID_ROWS` and `col<GRID_COLS`: `grid_ram[row*GRID_COLS+col] <= val`. The index is computed at 11-bit width.
  - Otherwise no bit changes and `err_oob` is set to 1 for the same cycle as `ack`.
- **Handshake rules:** the requester holds `row`/`col`/`val` stable while `req`=1 and `ack`=0. It may present new fields or drop `req` in the cycle `ack` is seen high. Dropping `req` before `ack` withdraws the request and causes no write.
- **Clear FSM**, states IDLE and CLEAR:
  - IDLE -> CLEAR when `clear_start`=1; `clear_row` <= 0.
  - In CLEAR, each cycle zeroes bits `[clear_row*GRID_COLS +: GRID_COLS]` and increments `clear_row`.
  - After row `GRID_ROWS-1` is zeroed, return to IDLE.
  - `clear_start` is ignored while in CLEAR.
- **Simultaneous events:**
  - No grants are issued in any cycle where the FSM is in CLEAR or `clear_start` is sampled in IDLE. Pending requests stall (`req` held) and are served after the FSM returns to IDLE.
  - The clear therefore never interleaves with a write. A write granted after the clear lands on the cleared grid.

## Timing
- **Reset values:** `grid_ram`=0 (all cells), `ack0`=`ack1`=0, `err_oob`=0, `clear_busy`=0, FSM=IDLE, `clear_row`=0, `last_grant`=1 (so `req0` wins the first tie).
- **Reset mid-operation:** aborts any clear or pending grant immediately. All the state above returns to its reset values.
- **Write latency:** `req` sampled at edge k -> `ack` and the `grid_ram` update are both visible after edge k. That is one cycle from `req` to `ack` when uncontended.
- **Contended latency:** worst-case wait with both requesters active is 2 cycles.
- **Clear timing:** `clear_start` at edge k -> `clear_busy` high from edge k for exactly `GRID_ROWS` cycles (30). Row r is zeroed at edge k+1+r. The first grant can occur at edge k+GRID_ROWS+1.

## Configuration
- **`GRID_ARB_CLEAR_EN` defined:** the clear FSM, `clear_row` and the stall logic are compiled in, as described above.
- **`GRID_ARB_CLEAR_EN` undefined:**
  - `clear_start` is ignored and `clear_busy` is tied to 0.
  - Grants never stall.
  - The grid is cleared only by `reset`.
  - All ports remain present.

## Test plan
- **Reset and single write:** after reset, `req0` with row=2, col=5, val=1 -> `ack0` one cycle later; `grid_ram[85]`=1; `err_oob`=0; all other bits 0.
- **Tie breaking:** `req0` and `req1` rise together (0,0,1) / (29,39,1), held -> `ack0` first, `ack1` next cycle; bits 0 and 1199 set. With both held continuously, acks alternate 0,1,0,1.
- **Out of range:** `req1` row=30 col=0 -> `ack1`=1 and `err_oob`=1 in the same cycle; `grid_ram` unchanged. Repeat with col=40: same response.
- **Clear with pending request:** set bits 0, 600 and 1199, then pulse `clear_start` while `req0` (0,0,1) is held -> `clear_busy` high for 30 cycles; no `ack0` during clear. Afterwards `grid_ram` equals only bit 0 set, with `ack0` one cycle after `clear_busy` falls.
- **Reset mid-clear:** assert `reset` at cycle 10 of a clear -> `clear_busy`=0 and `grid_ram`=0 immediately. After release, the FSM is IDLE and `req0` is served in 1 cycle.
- **Macro undefined:** build without `GRID_ARB_CLEAR_EN`; `clear_start` pulse with bits set -> `clear_busy` stays 0; bits retained; requests acked with no stall.
